// File: rtl/ecg_window_feeder.sv
// ----------------------------------------------------------------------------
// ecg_window_feeder
//
// This is the producer side of the node activation interface. It takes a
// serial stream of ECG samples and builds a sliding window of DEPTH slots.
// The window is presented in parallel to a layer of fully-parallel node
// blocks, where slot k drives node input A{k}x.
//
// The first window is issued after DEPTH accepted samples. After that, one
// window is issued for every STRIDE new samples. While a window is pending
// (win_valid && !win_ready), the sample stream is held off. node_done pulses
// LAT cycles after each window handshake, marking the moment the fixed-latency
// node pipeline presents valid outputs.
//
// Handshakes (both ports): a transfer happens on a rising clk edge when
// valid && ready. A producer holds valid and data stable until the transfer
// happens. s_ready is a combinational function of win_valid/win_ready, so a
// sample can be taken in the same cycle as a window handshake.
//
// Optional feature macro: FEED_CLAMP_EN
//   defined   : samples are clamped to 0..255 and zero-extended to WIDTH
//   undefined : samples are sign-extended from SAMPLE_W to WIDTH
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   s_valid    in   sample present
//   s_data     in   SAMPLE_W-bit two's complement sample
//   s_ready    out  sample accepted when s_valid && s_ready
//   flush      in   synchronous restart of the window fill
//   win_valid  out  window complete and stable
//   win_ready  in   downstream accepts the window
//   win_data   out  DEPTH slots; slot k = bits [WIDTH*k +: WIDTH], slot 0 oldest
//   node_done  out  one-cycle pulse, node outputs valid
//   win_count  out  number of windows handshaken, wraps modulo 2^16
// ----------------------------------------------------------------------------
module ecg_window_feeder #(
    parameter int DEPTH    = 75,
    parameter int WIDTH    = 24,
    parameter int SAMPLE_W = 12,
    parameter int STRIDE   = 25,
    parameter int LAT      = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic [SAMPLE_W-1:0]      s_data,
    output logic                     s_ready,
    input  logic                     flush,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [DEPTH*WIDTH-1:0]   win_data,
    output logic                     node_done,
    output logic [15:0]              win_count
);

    localparam int FILL_W   = $clog2(DEPTH + 1);
    localparam int STRIDE_W = 8;

    logic [FILL_W-1:0]   fill_cnt;
    logic [FILL_W-1:0]   fill_cnt_n;
    logic [STRIDE_W-1:0] stride_cnt;
    logic [STRIDE_W-1:0] stride_cnt_n;
    logic                win_valid_n;
    logic                accept;
    logic                win_hs;
    logic [WIDTH-1:0]    sample_ext;
    logic [LAT-1:0]      done_pipe;

    // Holding s_ready low during reset keeps the upstream from counting
    // transfers that the cleared state would never see.
    assign s_ready = reset & (~win_valid | win_ready);
    // flush wins over a same-cycle sample: that sample is dropped.
    assign accept  = s_valid & s_ready & ~flush;
    assign win_hs  = win_valid & win_ready;

`ifdef FEED_CLAMP_EN
    // Clamp the sample into the node activation range 0..255.
    always_comb begin
        sample_ext = '0;
        if (s_data[SAMPLE_W-1]) begin
            sample_ext = '0;
        end else if (32'(s_data) > 32'd255) begin
            sample_ext = WIDTH'(8'hFF);
        end else begin
            sample_ext = WIDTH'(s_data);
        end
    end
`else
    assign sample_ext = WIDTH'($signed(s_data));
`endif

    // The three states (FILL, STREAM, PENDING) are implied by fill_cnt,
    // stride_cnt and win_valid. This block computes their next values.
    always_comb begin
        fill_cnt_n   = fill_cnt;
        stride_cnt_n = stride_cnt;
        win_valid_n  = win_valid;

        if (win_hs) begin
            win_valid_n = 1'b0;
        end

        if (flush) begin
            fill_cnt_n   = '0;
            stride_cnt_n = '0;
            win_valid_n  = 1'b0;
        end else if (accept) begin
            if (fill_cnt < FILL_W'(DEPTH)) begin
                // FILL: the accept that brings the count to DEPTH completes
                // the first window.
                fill_cnt_n = fill_cnt + 1'b1;
                if (fill_cnt == FILL_W'(DEPTH - 1)) begin
                    win_valid_n  = 1'b1;
                    stride_cnt_n = '0;
                end
            end else if (stride_cnt < STRIDE_W'(STRIDE)) begin
                // STREAM: a window is completed every STRIDE accepts. A
                // completion overrides the handshake clear above, which
                // keeps win_valid high when STRIDE == 1.
                if (stride_cnt == STRIDE_W'(STRIDE - 1)) begin
                    win_valid_n  = 1'b1;
                    stride_cnt_n = '0;
                end else begin
                    stride_cnt_n = stride_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt   <= '0;
            stride_cnt <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            done_pipe  <= '0;
            win_count  <= '0;
        end else begin
            fill_cnt   <= fill_cnt_n;
            stride_cnt <= stride_cnt_n;
            win_valid  <= win_valid_n;
            // Shift toward slot 0. The newest sample enters the top slot.
            // Because accept needs s_ready, the window cannot change while a
            // window is pending and not yet taken.
            if (accept) begin
                win_data <= {sample_ext, win_data[DEPTH*WIDTH-1:WIDTH]};
            end
            // Handshake in cycle t shows up as done_pipe[LAT-1] in cycle t+LAT.
            done_pipe <= (done_pipe << 1) | LAT'(win_hs);
            win_count <= win_count + 16'(win_hs);
        end
    end

    assign node_done = done_pipe[LAT-1];

endmodule
